rr_sel_arbiter: RTL and testbench
=================================

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, sets the maximum cycles one grant is held; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request per downstream 4:1 mux data input; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-005 done  input  1  current owner finished; releases the grant.
REQ-006 grant  output  4  registered one-hot grant, same bit order as req.
REQ-007 sel  output  2  registered select for the downstream 4:1 mux.
REQ-008 valid  output  1  high while a grant is active, i.e. sel is meaningful.
REQ-009 timeout  output  1  one-cycle pulse on forced release at MAX_HOLD.

Function
REQ-010 Two states, IDLE and BUSY, held in a registered state variable.
REQ-011 sel encoding is fixed to the mux bit mapping: A=2'b00, B=2'b10, C=2'b01, D=2'b11, so sel[0] chooses the A/B vs C/D pair and sel[1] chooses within the pair.
REQ-012 A 2-bit round-robin pointer ptr gives the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
REQ-013 IDLE with req==0: stay IDLE; grant=0, valid=0; sel holds its last value.
REQ-014 IDLE with req!=0: pick the first requester in search order; at the next edge enter BUSY with grant, sel and valid=1 set (latency one cycle from the sampling edge).
REQ-015 BUSY: grant and sel stay constant; a 4-bit hold counter reads 1 in the first BUSY cycle and increments each further BUSY cycle.
REQ-016 BUSY release conditions are done=1, req[owner]=0, or counter==MAX_HOLD; any one returns to IDLE at the next edge.
REQ-017 On every release, ptr = owner+1 modulo 4 (wrap-around 3 to 0), and the counter is cleared.
REQ-018 timeout pulses high for exactly the IDLE cycle after a release caused only by counter==MAX_HOLD.
REQ-019 If done=1 or req[owner]=0 in the same cycle as counter==MAX_HOLD, the release is normal and timeout stays 0.
REQ-020 Every release passes through at least one IDLE cycle (valid=0) before any new grant; no back-to-back grants.
REQ-021 done is ignored in IDLE; requests from non-owners are ignored in BUSY.
REQ-022 MAX_HOLD=1 releases after exactly one BUSY cycle.

Reset
REQ-023 reset asserted forces, immediately and independent of clk: state=IDLE, grant=4'b0000, sel=2'b00, valid=0, timeout=0, ptr=0, counter=0.
REQ-024 reset asserted mid-BUSY abandons the grant without a timeout pulse; the first decision after deassertion uses ptr=0.

Structure
REQ-025 State encodings (IDLE, BUSY) and the four sel code constants are defined in one shared package/include used by this block and the mux benches.
REQ-026 One combinational sub-module, rr_pick (inputs req, ptr; outputs one-hot pick and any-request flag), is instantiated once; the FSM, counter and registers are in rr_sel_arbiter.

Verification
REQ-027 reset, then req=4'b0001 -> one cycle later grant=0001, sel=00, valid=1.
REQ-028 req=4'b1111 held, done pulsed in each BUSY cycle -> grants 0001,0010,0100,1000,0001 with sel 00,10,01,11,00, and one valid=0 cycle between each grant.
REQ-029 MAX_HOLD=8, req=4'b0100 held, done=0 -> grant 0100 for 8 cycles, then one IDLE cycle with timeout=1, then 0100 is granted again.
REQ-030 After C (0100) is released, ptr=3; req=4'b0011 -> grant=0001 (A), sel=00.
REQ-031 reset pulsed mid-BUSY with grant=0100 -> all outputs 0 asynchronously; after deassertion, req=4'b1010 -> grant=0010.
REQ-032 done=1 on the MAX_HOLD cycle -> release with timeout=0; req[owner] dropped mid-BUSY -> release at the next edge.

Source files
------------

// File: rtl/rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter and the downstream
// 4:1 mux benches: FSM state encoding, mux select codes and index helpers.
package rr_sel_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Select codes follow the mux wiring: sel[0] picks the A/B or C/D pair,
    // sel[1] picks the member within the pair.
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_C = 2'b01;
    localparam logic [1:0] SEL_D = 2'b11;

    // Requester index (0=A .. 3=D) to mux select code.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = SEL_A;
            2'd1:    code = SEL_B;
            2'd2:    code = SEL_C;
            2'd3:    code = SEL_D;
            default: code = SEL_A;
        endcase
        return code;
    endfunction

    // One-hot requester vector to index; non-one-hot values map to A.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational round-robin picker: the first set request bit found when
// searching upward from ptr (modulo 4) is returned one-hot.
module rr_pick
    import rr_sel_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] pick,
    output logic       any
);

    logic       found_s;
    logic [1:0] idx_s;

    // Walk the four positions in priority order and keep the first hit.
    always_comb begin
        pick    = 4'b0000;
        found_s = 1'b0;
        idx_s   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr + 2'(i);
            if (!found_s && req[idx_s]) begin
                pick[idx_s] = 1'b1;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select. A grant is held until the
// owner signals done, drops its request, or has held it MAX_HOLD cycles.
// Every release is followed by at least one idle cycle.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic       timeout
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    arb_state_t state_r, state_s;
    logic [1:0] ptr_r, ptr_s;
    logic [3:0] cnt_r, cnt_s;
    logic [3:0] grant_s;
    logic [1:0] sel_s;
    logic       valid_s;
    logic       timeout_s;
    logic [3:0] pick_s;
    logic       any_s;
    logic [1:0] owner_s;
    logic       at_limit_s;
    logic       release_s;

    rr_pick u_pick (
        .req  (req),
        .ptr  (ptr_r),
        .pick (pick_s),
        .any  (any_s)
    );

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        cnt_s      = cnt_r;
        grant_s    = grant;
        sel_s      = sel;
        valid_s    = valid;
        timeout_s  = 1'b0;
        owner_s    = onehot_to_idx(grant);
        at_limit_s = (cnt_r == HOLD_LIMIT);
        release_s  = done | ~req[owner_s] | at_limit_s;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_s = ST_BUSY;
                    grant_s = pick_s;
                    sel_s   = idx_to_sel(onehot_to_idx(pick_s));
                    valid_s = 1'b1;
                    cnt_s   = 4'd1;
                end else begin
                    grant_s = 4'b0000;
                    valid_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (release_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = 4'b0000;
                    valid_s   = 1'b0;
                    cnt_s     = 4'd0;
                    ptr_s     = owner_s + 2'd1;
                    // Only a pure hold-limit expiry counts as a timeout.
                    timeout_s = at_limit_s & ~done & req[owner_s];
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                valid_s = 1'b0;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= 4'd0;
            grant   <= 4'b0000;
            sel     <= SEL_A;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            grant   <= grant_s;
            sel     <= sel_s;
            valid   <= valid_s;
            timeout <= timeout_s;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=8 and MAX_HOLD=1) share the
// same stimulus and are compared every cycle against a behavioural model;
// directed sequences pin the model with hand-computed values.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;

    logic [3:0] grant8, grant1;
    logic [1:0] sel8, sel1;
    logic       valid8, valid1, timeout8, timeout1;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  cmp_en   = 1'b0;

    always #5 clk = ~clk;

    rr_sel_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant8), .sel(sel8), .valid(valid8), .timeout(timeout8)
    );

    rr_sel_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant1), .sel(sel1), .valid(valid1), .timeout(timeout1)
    );

    // ---------------- behavioural model ----------------
    // owner = -1 means no grant; otherwise index of the granted requester.
    logic [1:0] sel_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    int         m_owner   [2];
    int         m_ptr     [2];
    int         m_hold    [2];
    logic [1:0] m_sel     [2];
    logic       m_timeout [2];

    function automatic int hold_of(input int u);
        return (u == 0) ? 8 : 1;
    endfunction

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Model advance on each clock edge, cleared by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                m_owner[u]   <= -1;
                m_ptr[u]     <= 0;
                m_hold[u]    <= 0;
                m_sel[u]     <= 2'b00;
                m_timeout[u] <= 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (m_owner[u] < 0) begin
                    m_timeout[u] <= 1'b0;
                    if (req != 4'b0000) begin
                        m_owner[u] <= first_req(req, m_ptr[u]);
                        m_sel[u]   <= sel_tab[first_req(req, m_ptr[u])];
                        m_hold[u]  <= 1;
                    end
                end else if (done || !req[m_owner[u]] || m_hold[u] == hold_of(u)) begin
                    m_timeout[u] <= (m_hold[u] == hold_of(u)) && !done && req[m_owner[u]];
                    m_ptr[u]     <= (m_owner[u] + 1) % 4;
                    m_owner[u]   <= -1;
                    m_hold[u]    <= 0;
                end else begin
                    m_hold[u] <= m_hold[u] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic cmp_unit(input int u, input logic [3:0] g, input logic [1:0] s,
                            input logic v, input logic t);
        logic [3:0] eg;
        eg = (m_owner[u] >= 0) ? (4'b0001 << m_owner[u]) : 4'b0000;
        check($sformatf("model%0d.grant", u), g, eg);
        check($sformatf("model%0d.sel", u), {2'b00, s}, {2'b00, m_sel[u]});
        check($sformatf("model%0d.valid", u), {3'b000, v}, {3'b000, m_owner[u] >= 0});
        check($sformatf("model%0d.timeout", u), {3'b000, t}, {3'b000, m_timeout[u]});
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_unit(0, grant8, sel8, valid8, timeout8);
            cmp_unit(1, grant1, sel1, valid1, timeout1);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input logic t);
        check({name, ".grant"}, grant8, g);
        check({name, ".sel"}, {2'b00, sel8}, {2'b00, s});
        check({name, ".valid"}, {3'b000, valid8}, {3'b000, v});
        check({name, ".timeout"}, {3'b000, timeout8}, {3'b000, t});
    endtask

    logic [3:0] rr_grants [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_sels   [5] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #2 reset = 1'b1;
        tick();
        tick();
        chk8("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        cmp_en = 1'b1;
        reset  = 1'b0;
        tick();

        // First grant one cycle after the request is sampled.
        req = 4'b0001;
        tick();
        chk8("first_grant", 4'b0001, 2'b00, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk8("req_drop_release", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Full rotation with done held high; one idle cycle between grants.
        reset = 1'b1;
        #1 reset = 1'b0;
        req  = 4'b1111;
        done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk8($sformatf("rotate%0d", k), rr_grants[k], rr_sels[k], 1'b1, 1'b0);
            tick();
            chk8($sformatf("rotate_gap%0d", k), 4'b0000, rr_sels[k], 1'b0, 1'b0);
        end
        req  = 4'b0000;
        done = 1'b0;
        tick();

        // Hold-limit expiry: 8 cycles of C, idle with timeout, C again.
        req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk8($sformatf("hold%0d", k + 1), 4'b0100, 2'b01, 1'b1, 1'b0);
            if (k == 0) check("hold1_grant", grant1, 4'b0100);
            if (k == 1) begin
                check("hold1_valid", {3'b000, valid1}, 4'b0000);
                check("hold1_timeout", {3'b000, timeout1}, 4'b0001);
            end
        end
        tick();
        chk8("timeout_idle", 4'b0000, 2'b01, 1'b0, 1'b1);
        tick();
        chk8("regrant_c", 4'b0100, 2'b01, 1'b1, 1'b0);

        // After C releases, ptr=3 so A wins over B.
        req = 4'b0011;
        tick();
        chk8("c_release", 4'b0000, 2'b01, 1'b0, 1'b0);
        tick();
        chk8("ptr_wrap", 4'b0001, 2'b00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a C grant.
        req = 4'b0100;
        tick();
        tick();
        chk8("pre_reset_c", 4'b0100, 2'b01, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk8("async_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        req   = 4'b1010;
        tick();
        chk8("post_reset_b", 4'b0010, 2'b10, 1'b1, 1'b0);

        // done on the limit cycle gives a normal release.
        for (int k = 0; k < 7; k++) tick();
        chk8("b_hold8", 4'b0010, 2'b10, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk8("done_at_limit", 4'b0000, 2'b10, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk8("grant_d", 4'b1000, 2'b11, 1'b1, 1'b0);
        tick();
        req = 4'b0010;
        tick();
        chk8("owner_drop", 4'b0000, 2'b11, 1'b0, 1'b0);

        // Randomised traffic, with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
